mailbox_apb_bridge: RTL

//  APB3 slave that fronts one side (A or B) of the mailbox controller.

---
 rtl/mailbox_pkg.sv | 33 +++
 rtl/mailbox_apb_bridge_timeout_ctr.sv | 35 +++
 rtl/mailbox_apb_bridge.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mailbox_pkg.sv
// Shared types and register map for the mailbox APB bridge.
package mailbox_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mbx_state_e;

  localparam logic [5:0] MBX_VERSION = 6'h00;
  localparam logic [5:0] MBX_CTRL    = 6'h04;
  localparam logic [5:0] MBX_HART    = 6'h08;
  localparam logic [5:0] MBX_DEPTH   = 6'h0C;
  localparam logic [5:0] MBX_RX_BASE = 6'h20;
  localparam logic [5:0] MBX_TX_BASE = 6'h30;

  // Byte offsets are decoded at word granularity.
  function automatic logic legal_rd(input logic [5:0] off);
    logic [3:0] w;
    w = off[5:2];
    return (w == MBX_VERSION[5:2]) ||
           (w == MBX_CTRL[5:2]) ||
           (w == MBX_HART[5:2]) ||
           (w == MBX_DEPTH[5:2]) ||
           (off[5:4] == MBX_RX_BASE[5:4]);
  endfunction

  function automatic logic legal_wr(input logic [5:0] off);
    return (off == MBX_CTRL) ||
           (off[5:4] == MBX_TX_BASE[5:4]);
  endfunction

endpackage

// File: rtl/mailbox_apb_bridge_timeout_ctr.sv
// WAIT-cycle counter for the mailbox APB bridge.
// Flags expiry when the count reaches TIMEOUT_CYCLES-1.
module mailbox_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mailbox_apb_bridge.sv
// APB3 slave fronting one side of the mailbox controller.
// Define MAILBOX_BRIDGE_ADDR_CHECK_EN to reject unmapped offsets locally.
module mailbox_apb_bridge
  import mailbox_pkg::*;
#(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              mbx_write,
  output logic              mbx_read,
  output logic [5:0]        mbx_addr,
  output logic [31:0]       mbx_wdata,
  input  logic              mbx_ready,
  input  logic [31:0]       mbx_rdata,
  output logic              timeout_o
);

  mbx_state_e  state_q, state_d;
  logic [31:0] prdata_q, prdata_d;
  logic [31:0] wdata_q, wdata_d;
  logic [5:0]  addr_q, addr_d;
  logic        pready_q, pready_d;
  logic        err_q, err_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic        to_q, to_d;
  logic        access, legal;
  logic        ctr_clr, ctr_en, expired;

  assign access = psel & penable;

`ifdef MAILBOX_BRIDGE_ADDR_CHECK_EN
  logic upper_zero;
  assign upper_zero = ((paddr >> 6) == '0);
  assign legal = upper_zero &
                 (pwrite ? legal_wr(paddr[5:0])
                         : legal_rd(paddr[5:0]));
`else
  logic unused_paddr;
  assign unused_paddr = ^(paddr >> 6);
  assign legal = 1'b1;
`endif

  mailbox_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_ctr (
    .clk      (clk),
    .resetn   (resetn),
    .clr_i    (ctr_clr),
    .en_i     (ctr_en),
    .expired_o(expired)
  );

  always_comb begin
    state_d  = state_q;
    prdata_d = prdata_q;
    wdata_d  = wdata_q;
    addr_d   = addr_q;
    err_d    = err_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    pready_d = 1'b0;
    to_d     = 1'b0;
    ctr_clr  = 1'b0;
    ctr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        prdata_d = '0;
        err_d    = 1'b0;
        if (access && legal) begin
          addr_d  = paddr[5:0];
          wdata_d = pwdata;
          wr_d    = pwrite;
          rd_d    = !pwrite;
          ctr_clr = 1'b1;
          state_d = WAIT;
        end else if (access) begin
          err_d    = 1'b1;
          pready_d = 1'b1;
          state_d  = RESP;
        end
      end
      WAIT: begin
        ctr_en = 1'b1;
        // A ready in the expiry cycle still counts as a normal completion.
        if (mbx_ready) begin
          wr_d     = 1'b0;
          rd_d     = 1'b0;
          prdata_d = wr_q ? '0 : mbx_rdata;
          err_d    = 1'b0;
          pready_d = 1'b1;
          state_d  = RESP;
        end else if (expired) begin
          wr_d     = 1'b0;
          rd_d     = 1'b0;
          prdata_d = '0;
          err_d    = 1'b1;
          to_d     = 1'b1;
          pready_d = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        prdata_d = '0;
        err_d    = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      prdata_q <= '0;
      wdata_q  <= '0;
      addr_q   <= '0;
      pready_q <= 1'b0;
      err_q    <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      prdata_q <= prdata_d;
      wdata_q  <= wdata_d;
      addr_q   <= addr_d;
      pready_q <= pready_d;
      err_q    <= err_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      to_q     <= to_d;
    end
  end

  assign prdata    = prdata_q;
  assign pready    = pready_q;
  assign pslverr   = err_q;
  assign mbx_write = wr_q;
  assign mbx_read  = rd_q;
  assign mbx_addr  = addr_q;
  assign mbx_wdata = wdata_q;
  assign timeout_o = to_q;

endmodule
